// File: rtl/dma_copy_engine.sv
// Memory-to-memory word copy engine: slave register block (SRC/DST/LEN/CTRL)
// plus a bus master that streams read-then-write word transfers.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   address_in .. ready_out   slave register port (zero-wait, OR-bus read data)
//   m_address_out .. m_fault_in  master request port into the bus arbiter
//   done_out              one-cycle pulse on completion or fault
module dma_copy_engine #(
  parameter int LEN_BITS = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   address_in,
  input  logic          sel_in,
  input  logic          read_in,
  output logic [31:0]   read_value_out,
  input  logic [3:0]    write_mask_in,
  input  logic [31:0]   write_value_in,
  output logic          ready_out,
  output logic [31:0]   m_address_out,
  output logic          m_read_out,
  output logic          m_write_out,
  input  logic [31:0]   m_read_value_in,
  output logic [3:0]    m_write_mask_out,
  output logic [31:0]   m_write_value_out,
  input  logic          m_ready_in,
  input  logic          m_fault_in,
  output logic          done_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic [LEN_BITS-1:0] ONE = 1;

  state_t              state_q;
  logic [31:0]         src_q, dst_q;
  logic [LEN_BITS-1:0] len_q;
  logic                busy_q, done_q, err_q, done_out_q;
  logic [31:0]         cur_src_q, cur_dst_q, buf_q;
  logic [LEN_BITS-1:0] rem_q;

  logic [1:0]  reg_sel;
  logic        wr_en, start;
  logic [31:0] len_ext, src_d, dst_d, len_d, rdata;

  // Only address bits [3:2] select a register; the strobe is implied by sel_in.
  logic unused_ok;
  assign unused_ok = ^{read_in, address_in[31:4], address_in[1:0]};

  function automatic logic [31:0] merge(
    input logic [31:0] o,
    input logic [31:0] n,
    input logic [3:0]  m
  );
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = m[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  assign reg_sel = address_in[3:2];
  assign len_ext = 32'(len_q);
  assign src_d   = merge(src_q, write_value_in, write_mask_in);
  assign dst_d   = merge(dst_q, write_value_in, write_mask_in);
  assign len_d   = merge(len_ext, write_value_in, write_mask_in);

  // Register writes (and start) are locked out for the whole transfer.
  assign wr_en = sel_in & (|write_mask_in) & ~busy_q;
  assign start = wr_en & (reg_sel == 2'd3)
               & write_mask_in[0] & write_value_in[0];

  assign ready_out = sel_in;
  assign done_out  = done_out_q;

  always_comb begin
    rdata = '0;
    unique case (reg_sel)
      2'd0: rdata = src_q;
      2'd1: rdata = dst_q;
      2'd2: rdata = len_ext;
      2'd3: rdata = {29'b0, err_q, done_q, busy_q};
    endcase
    read_value_out = sel_in ? rdata : 32'h0;
  end

  // Requests are gated by reset so they drop in the reset cycle itself.
  always_comb begin
    m_address_out     = '0;
    m_read_out        = 1'b0;
    m_write_out       = 1'b0;
    m_write_mask_out  = '0;
    m_write_value_out = '0;
    if (!reset) begin
      unique case (1'b1)
        state_q == READ: begin
          m_address_out = cur_src_q;
          m_read_out    = 1'b1;
        end
        state_q == WRITE: begin
          m_address_out     = cur_dst_q;
          m_write_out       = 1'b1;
          m_write_mask_out  = 4'b1111;
          m_write_value_out = buf_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      done_out_q <= 1'b0;
      cur_src_q  <= '0;
      cur_dst_q  <= '0;
      rem_q      <= '0;
      buf_q      <= '0;
    end else begin
      done_out_q <= 1'b0;
      if (wr_en) begin
        unique case (reg_sel)
          2'd0: src_q <= src_d;
          2'd1: dst_q <= dst_d;
          2'd2: len_q <= len_d[LEN_BITS-1:0];
          2'd3: ;
        endcase
      end
      unique case (state_q)
        IDLE: begin
          if (start) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (len_q != '0) begin
              busy_q    <= 1'b1;
              cur_src_q <= {src_q[31:2], 2'b00};
              cur_dst_q <= {dst_q[31:2], 2'b00};
              rem_q     <= len_q;
              state_q   <= READ;
            end else begin
              done_q     <= 1'b1;
              done_out_q <= 1'b1;
            end
          end
        end
        READ: begin
          if (m_ready_in) begin
            if (m_fault_in) begin
              state_q    <= IDLE;
              busy_q     <= 1'b0;
              err_q      <= 1'b1;
              done_q     <= 1'b1;
              done_out_q <= 1'b1;
            end else begin
              buf_q   <= m_read_value_in;
              state_q <= WRITE;
            end
          end
        end
        WRITE: begin
          if (m_ready_in) begin
            if (m_fault_in) begin
              state_q    <= IDLE;
              busy_q     <= 1'b0;
              err_q      <= 1'b1;
              done_q     <= 1'b1;
              done_out_q <= 1'b1;
            end else begin
              cur_src_q <= cur_src_q + 32'd4;
              cur_dst_q <= cur_dst_q + 32'd4;
              rem_q     <= rem_q - ONE;
              if (rem_q == ONE) begin
                state_q    <= IDLE;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
                done_out_q <= 1'b1;
              end else begin
                state_q <= READ;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Self-checking bench for dma_copy_engine: bus RAM responder with wait
// states and fault injection, transaction-level reference model, directed tests.
module tb_dma_copy_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address_in;
  logic        sel_in, read_in;
  logic [31:0] read_value_out;
  logic [3:0]  write_mask_in;
  logic [31:0] write_value_in;
  logic        ready_out;
  logic [31:0] m_address_out;
  logic        m_read_out, m_write_out;
  logic [31:0] m_read_value_in;
  logic [3:0]  m_write_mask_out;
  logic [31:0] m_write_value_out;
  logic        m_ready_in, m_fault_in;
  logic        done_out;

  dma_copy_engine #(.LEN_BITS(16)) dut (
    .clk(clk), .reset(reset),
    .address_in(address_in), .sel_in(sel_in), .read_in(read_in),
    .read_value_out(read_value_out), .write_mask_in(write_mask_in),
    .write_value_in(write_value_in), .ready_out(ready_out),
    .m_address_out(m_address_out), .m_read_out(m_read_out),
    .m_write_out(m_write_out), .m_read_value_in(m_read_value_in),
    .m_write_mask_out(m_write_mask_out),
    .m_write_value_out(m_write_value_out),
    .m_ready_in(m_ready_in), .m_fault_in(m_fault_in),
    .done_out(done_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
  } op_t;

  op_t         expq[$];
  logic [31:0] hlog[$];
  logic [31:0] mem[logic [31:0]];
  logic [31:0] m_src, m_dst;
  logic [15:0] m_len;
  logic        m_busy, m_done, m_err;
  bit          pending_done;
  int          cyc = 0, start_cyc = 0, last_lat = -1;
  int          waits = 0, fault_at = -1, op_idx = 0, wcnt = 0;

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] bmerge(input logic [31:0] o,
                                         input logic [31:0] n,
                                         input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = m[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  task automatic model_clear();
    m_src = 0; m_dst = 0; m_len = 0;
    m_busy = 0; m_done = 0; m_err = 0;
    pending_done = 0;
    expq.delete();
  endtask

  task automatic model_start();
    logic [31:0] s, d;
    m_done = 0; m_err = 0;
    op_idx = 0;
    start_cyc = cyc;
    if (m_len == 0) begin
      m_done = 1;
      pending_done = 1;
    end else begin
      m_busy = 1;
      for (int i = 0; i < int'(m_len); i++) begin
        s = {m_src[31:2], 2'b00} + 32'(4 * i);
        d = {m_dst[31:2], 2'b00} + 32'(4 * i);
        expq.push_back('{s, 1'b0, 32'h0});
        expq.push_back('{d, 1'b1, rd_mem(s)});
      end
    end
  endtask

  // ---------------- bus RAM responder ----------------
  initial begin
    m_ready_in = 0; m_fault_in = 0; m_read_value_in = 0;
    forever begin
      @(posedge clk); #2;
      if (m_read_out || m_write_out) begin
        if (wcnt >= waits) begin
          m_ready_in = 1;
          m_fault_in = (op_idx == fault_at);
          if (m_read_out)
            m_read_value_in = rd_mem(m_address_out);
          else if (!m_fault_in)
            mem[m_address_out] = m_write_value_out;
          op_idx++;
          wcnt = 0;
        end else begin
          m_ready_in = 0; m_fault_in = 0;
          wcnt++;
        end
      end else begin
        m_ready_in = 0; m_fault_in = 0; wcnt = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic        have_prev = 0;
  logic [31:0] p_addr, p_wval;
  logic [1:0]  p_rw;

  initial begin
    bit exp_done;
    forever begin
      @(negedge clk);
      cyc++;
      exp_done = pending_done;
      pending_done = 0;
      chk("done_out", 32'(done_out), 32'(exp_done));
      if (done_out) last_lat = cyc - start_cyc;
      if (!sel_in) chk("rdata_unsel", read_value_out, 32'h0);
      if (!m_busy || reset) begin
        chk("idle_req", 32'({m_read_out, m_write_out, m_write_mask_out}), 32'h0);
        have_prev = 0;
      end else begin
        chk("req_onehot", 32'(m_read_out ^ m_write_out), 32'h1);
        chk("mask", 32'(m_write_mask_out), m_write_out ? 32'hF : 32'h0);
        chk("addr_align", 32'(m_address_out[1:0]), 32'h0);
        if (have_prev) begin
          chk("stable_addr", m_address_out, p_addr);
          chk("stable_rw", 32'({m_read_out, m_write_out}), 32'(p_rw));
          chk("stable_wval", m_write_value_out, p_wval);
        end
        have_prev = !m_ready_in;
        p_addr = m_address_out;
        p_rw   = {m_read_out, m_write_out};
        p_wval = m_write_value_out;
        if (m_ready_in) begin
          op_t op;
          hlog.push_back(m_address_out);
          chk("xfer_expected", 32'(expq.size() > 0), 32'h1);
          if (expq.size() > 0) begin
            op = expq.pop_front();
            chk("xfer_addr", m_address_out, op.addr);
            chk("xfer_dir", 32'(m_write_out), 32'(op.wr));
            if (op.wr) chk("xfer_wdata", m_write_value_out, op.data);
          end
          if (m_fault_in) begin
            expq.delete();
            m_busy = 0; m_done = 1; m_err = 1;
            pending_done = 1;
          end else if (expq.size() == 0) begin
            m_busy = 0; m_done = 1;
            pending_done = 1;
          end
        end
      end
    end
  end

  // ---------------- slave access ----------------
  task automatic slv(input logic [1:0] r, input logic [3:0] mask,
                     input logic [31:0] d, output logic [31:0] q);
    logic bz;
    @(posedge clk); #1;
    address_in     = 32'h4000_0000 | {28'h0, r, 2'b00};
    sel_in         = 1;
    read_in        = (mask == 0);
    write_mask_in  = mask;
    write_value_in = d;
    bz = m_busy;
    @(negedge clk);
    q = read_value_out;
    chk("ready_out", 32'(ready_out), 32'h1);
    #1;
    if (mask != 0 && !bz) begin
      case (r)
        2'd0: m_src = bmerge(m_src, d, mask);
        2'd1: m_dst = bmerge(m_dst, d, mask);
        2'd2: m_len = 16'(bmerge(32'(m_len), d, mask));
        default: if (mask[0] && d[0]) model_start();
      endcase
    end
    @(posedge clk); #1;
    sel_in = 0; read_in = 0; write_mask_in = 0;
    write_value_in = 0; address_in = 0;
  endtask

  task automatic wr(input logic [1:0] r, input logic [31:0] d);
    logic [31:0] q;
    slv(r, 4'hF, d, q);
  endtask

  task automatic rd_chk(input string name, input logic [1:0] r,
                        input logic [31:0] exp);
    logic [31:0] q;
    slv(r, 4'h0, 32'h0, q);
    chk(name, q, exp);
  endtask

  function automatic logic [31:0] model_status();
    return {29'b0, m_err, m_done, m_busy};
  endfunction

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400 && m_busy; i++) @(negedge clk);
    chk({name, "_timeout"}, 32'(m_busy), 32'h0);
    repeat (3) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1;
    model_clear();
    @(negedge clk);
    chk("rst_cycle_req",
        32'({m_read_out, m_write_out, m_write_mask_out}), 32'h0);
    @(posedge clk); #1;
    reset = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen;
    reset = 1; sel_in = 0; read_in = 0; address_in = 0;
    write_mask_in = 0; write_value_in = 0;
    model_clear();
    mem[32'h100] = 32'hA1A1_0001;
    mem[32'h104] = 32'hB2B2_0002;
    mem[32'h108] = 32'hC3C3_0003;
    mem[32'h300] = 32'h0BAD_0000;
    mem[32'h304] = 32'h0BAD_0001;
    mem[32'h308] = 32'h0BAD_0002;
    repeat (3) @(posedge clk);
    #1 reset = 0;

    // reset state
    rd_chk("rst_src", 2'd0, 32'h0);
    rd_chk("rst_dst", 2'd1, 32'h0);
    rd_chk("rst_len", 2'd2, 32'h0);
    rd_chk("rst_status", 2'd3, 32'h0);

    // basic 3-word copy, zero-wait
    hlog.delete();
    wr(2'd0, 32'h100); wr(2'd1, 32'h200); wr(2'd2, 32'h3);
    wr(2'd3, 32'h1);
    wait_idle("t1");
    chk("t1_nxfer", 32'(hlog.size()), 32'd6);
    if (hlog.size() == 6) begin
      chk("t1_a0", hlog[0], 32'h100); chk("t1_a1", hlog[1], 32'h200);
      chk("t1_a2", hlog[2], 32'h104); chk("t1_a3", hlog[3], 32'h204);
      chk("t1_a4", hlog[4], 32'h108); chk("t1_a5", hlog[5], 32'h208);
    end
    chk("t1_latency", 32'(last_lat), 32'd7);
    chk("t1_dst0", rd_mem(32'h200), 32'hA1A1_0001);
    chk("t1_dst2", rd_mem(32'h208), 32'hC3C3_0003);
    rd_chk("t1_status", 2'd3, 32'h2);
    rd_chk("t1_src", 2'd0, 32'h100);
    rd_chk("t1_len", 2'd2, 32'h3);

    // byte-masked write to SRC
    begin
      logic [31:0] q;
      slv(2'd0, 4'b0011, 32'hFFFF_1234, q);
    end
    rd_chk("bmask_src", 2'd0, 32'h0000_1234);

    // LEN = 0
    hlog.delete();
    wr(2'd2, 32'h0);
    wr(2'd3, 32'h1);
    wait_idle("t2");
    chk("t2_nxfer", 32'(hlog.size()), 32'd0);
    chk("t2_latency", 32'(last_lat), 32'd1);
    rd_chk("t2_status", 2'd3, 32'h2);

    // fault on second read, unaligned SRC stored as written
    hlog.delete();
    fault_at = 2;
    wr(2'd0, 32'h303); wr(2'd1, 32'h400); wr(2'd2, 32'h3);
    wr(2'd3, 32'h1);
    wait_idle("t3");
    fault_at = -1;
    chk("t3_nxfer", 32'(hlog.size()), 32'd3);
    chk("t3_dst0", rd_mem(32'h400), 32'h0BAD_0000);
    chk("t3_dst1_untouched", 32'(mem.exists(32'h404)), 32'h0);
    rd_chk("t3_status", 2'd3, 32'h6);
    rd_chk("t3_src", 2'd0, 32'h303);

    // 3 wait states, 2 words: 2*(1+3) cycles per word
    waits = 3;
    wr(2'd0, 32'h100); wr(2'd1, 32'h500); wr(2'd2, 32'h2);
    wr(2'd3, 32'h1);
    wait_idle("t4");
    chk("t4_latency", 32'(last_lat), 32'd17);
    chk("t4_dst1", rd_mem(32'h504), 32'hB2B2_0002);
    rd_chk("t4_status", 2'd3, model_status());

    // writes and restart while busy are ignored
    hlog.delete();
    waits = 1;
    wr(2'd1, 32'h600); wr(2'd2, 32'h3);
    wr(2'd3, 32'h1);
    wr(2'd0, 32'hDEAD_BEEF);
    wr(2'd3, 32'h1);
    rd_chk("t5_status_busy", 2'd3, 32'h1);
    wait_idle("t5");
    chk("t5_nxfer", 32'(hlog.size()), 32'd6);
    if (hlog.size() == 6) chk("t5_a4", hlog[4], 32'h108);
    chk("t5_dst2", rd_mem(32'h608), 32'hC3C3_0003);
    rd_chk("t5_src", 2'd0, 32'h100);

    // reset during WRITE
    waits = 3;
    wr(2'd1, 32'h700); wr(2'd2, 32'h2);
    wr(2'd3, 32'h1);
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = m_write_out;
    end
    chk("t6_saw_write", 32'(seen), 32'h1);
    do_reset();
    @(negedge clk);
    chk("t6_m_idle", 32'({m_read_out, m_write_out, m_write_mask_out}), 32'h0);
    chk("t6_m_addr", m_address_out, 32'h0);
    chk("t6_m_wval", m_write_value_out, 32'h0);
    chk("t6_no_dst", 32'(mem.exists(32'h700)), 32'h0);
    rd_chk("t6_status", 2'd3, 32'h0);
    rd_chk("t6_src", 2'd0, 32'h0);
    waits = 0;
    wr(2'd0, 32'h104); wr(2'd1, 32'h800); wr(2'd2, 32'h1);
    wr(2'd3, 32'h1);
    wait_idle("t6b");
    chk("t6b_latency", 32'(last_lat), 32'd3);
    chk("t6b_dst", rd_mem(32'h800), 32'hB2B2_0002);
    rd_chk("t6b_status", 2'd3, 32'h2);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
